instr_fetch: RTL

//  Reader side of the 16-bit program ROM. Drives the ROM address from a program counter,

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/instr_fetch_if.sv | 37 +++
 rtl/instr_fetch_decode.sv | 25 ++
 rtl/instr_fetch.sv | 111 +++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch slice.
//   state_t   : fetch FSM states (IDLE, RUN, DONE)
//   OPC_HALT  : opcode that stops fetching
//   *_LO/*_W  : bit positions and widths of the 16-bit instruction fields
//   is_halt() : true when a word carries the HALT opcode
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0]  OPC_HALT = 4'h0;

  localparam int unsigned FIELD_W  = 4;
  localparam int unsigned IMM_W    = 8;
  localparam int unsigned OPC_LO   = 12;
  localparam int unsigned RD_LO    = 8;
  localparam int unsigned RS_LO    = 4;
  localparam int unsigned RT_LO    = 0;
  localparam int unsigned IMM_LO   = 0;

  function automatic logic is_halt(input logic [15:0] word);
    return word[OPC_LO +: FIELD_W] == OPC_HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundles the ROM read port, the execute-stage valid/ready
// handshake, the redirect request and the control/status lines.
//   master : the fetch unit (drives rom_addr, instr*, fields, busy, done)
//   slave  : the environment (drives start, rom_data, instr_ready, redirect*)
interface instr_fetch_if #(
  parameter int ADDR_W  = 3,
  parameter int INSTR_W = 16
);
  logic               start;
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic [3:0]         opcode;
  logic [3:0]         rd;
  logic [3:0]         rs;
  logic [3:0]         rt;
  logic [7:0]         imm8;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               busy;
  logic               done;

  modport master (
    input  start, rom_data, instr_ready, redirect, redirect_pc,
    output rom_addr, instr_valid, instr, instr_pc,
           opcode, rd, rs, rt, imm8, busy, done
  );

  modport slave (
    output start, rom_data, instr_ready, redirect, redirect_pc,
    input  rom_addr, instr_valid, instr, instr_pc,
           opcode, rd, rs, rt, imm8, busy, done
  );
endinterface

// File: rtl/instr_fetch_decode.sv
// instr_decode: purely combinational split of an instruction word into fields.
//   instr  in  : instruction register contents
//   opcode out : instr[15:12]
//   rd     out : instr[11:8]
//   rs     out : instr[7:4]
//   rt     out : instr[3:0]
//   imm8   out : instr[7:0]
module instr_decode
  import fetch_pkg::*;
#(
  parameter int INSTR_W = 16
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [3:0]         rd,
  output logic [3:0]         rs,
  output logic [3:0]         rt,
  output logic [7:0]         imm8
);
  assign opcode = instr[OPC_LO +: FIELD_W];
  assign rd     = instr[RD_LO  +: FIELD_W];
  assign rs     = instr[RS_LO  +: FIELD_W];
  assign rt     = instr[RT_LO  +: FIELD_W];
  assign imm8   = instr[IMM_LO +: IMM_W];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: reader side of the program ROM. A PC drives rom_addr; the
// combinational ROM word is captured into an instruction register and offered
// to the execute stage over valid/ready. Supports redirect with flush and HALT.
//   clk, rst : clock; synchronous active-high reset
//   bus      : instr_fetch_if.master (ROM port, handshake, redirect, busy/done)
// Build option: FETCH_WRAP_EN -- when defined the PC wraps from the last ROM
// address to 0 and fetching continues; otherwise the last capture ends the run.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 3,
  parameter int INSTR_W = 16
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_if.master bus
);

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic [INSTR_W-1:0] instr_q, instr_nxt;
  logic [ADDR_W-1:0]  ipc_q, ipc_nxt;
  logic               valid_q, valid_nxt;
  logic               slot_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      instr_q <= instr_nxt;
      ipc_q   <= ipc_nxt;
      valid_q <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr_q;
    ipc_nxt   = ipc_q;
    valid_nxt = valid_q;
    slot_free = !valid_q || bus.instr_ready;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
        end
      end

      RUN: begin
        // Redirect wins over capture: the held word is flushed and the next
        // capture comes from the new target.
        if (bus.redirect) begin
          pc_nxt    = bus.redirect_pc;
          valid_nxt = 1'b0;
        end else if (slot_free) begin
          instr_nxt = bus.rom_data;
          ipc_nxt   = pc;
          valid_nxt = 1'b1;
          if (is_halt(bus.rom_data[15:0])) begin
            state_nxt = DONE;
          end else begin
`ifdef FETCH_WRAP_EN
            pc_nxt = pc + ADDR_W'(1);
`else
            if (pc == '1) state_nxt = DONE;
            else          pc_nxt    = pc + ADDR_W'(1);
`endif
          end
        end
      end

      DONE: begin
        if (bus.redirect) begin
          state_nxt = RUN;
          pc_nxt    = bus.redirect_pc;
          valid_nxt = 1'b0;
        end else if (valid_q && bus.instr_ready) begin
          valid_nxt = 1'b0;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.rom_addr    = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.instr_valid = valid_q;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE) && !valid_q;

  instr_decode #(.INSTR_W(INSTR_W)) u_decode (
    .instr  (instr_q),
    .opcode (bus.opcode),
    .rd     (bus.rd),
    .rs     (bus.rs),
    .rt     (bus.rt),
    .imm8   (bus.imm8)
  );

endmodule
